// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory
// responder (slave).
//
// Handshake: a channel transfers on a rising clock edge where its valid and
// ready are both 1. Once valid is raised it stays up with stable payload until
// that edge; ready may be raised or lowered at any time.
//
// Signals:
//   req_valid/req_ready  request channel handshake
//   req_we               1 = write, 0 = read
//   req_addr[29:0]       word address (byte address [31:2])
//   req_wmask[3:0]       byte-lane write enables, bit i -> wdata[8i+7:8i]
//   req_wdata[31:0]      write data
//   rsp_valid/rsp_ready  response channel handshake
//   rsp_rdata[31:0]      read data, zero for write responses
//   rsp_we               write/read flag of the request being answered
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [29:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read or byte-masked write at a time,
// inserts WAIT_CYCLES wait states, performs the array access on a single edge
// and holds one response until the requester takes it.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   bus          dmem_responder_if slave modport (request + response channels)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// The word array is not reset; committed writes survive reset.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [3:0]              wmask_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    rsp_we_q;

  logic [31:0]             mem_q [DEPTH];

  // Access selection: with zero wait states the access happens on the accept
  // edge straight from the request bus, otherwise on the last WAIT edge from
  // the latched request.
  logic                    acc_en;
  logic                    acc_we;
  logic [DEPTH_LOG2-1:0]   acc_addr;
  logic [3:0]              acc_mask;
  logic [31:0]             acc_wdata;

  // Upper address bits alias by design.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr;

  always_comb begin
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_mask  = wmask_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE && WAIT_CYCLES == 0) begin
      acc_en    = bus.req_valid;
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr[DEPTH_LOG2-1:0];
      acc_mask  = bus.req_wmask;
      acc_wdata = bus.req_wdata;
    end else if (state_q == S_WAIT && cnt_q == 4'd1) begin
      acc_en = 1'b1;
    end
  end

  // Word array, byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem_q[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wmask_q  <= 4'd0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      rsp_we_q <= 1'b0;
    end else begin
      // Read data is the array word as it stood before this edge.
      if (acc_en) begin
        rdata_q  <= acc_we ? 32'h0 : mem_q[acc_addr];
        rsp_we_q <= acc_we;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[DEPTH_LOG2-1:0];
            wmask_q <= bus.req_wmask;
            wdata_q <= bus.req_wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_we    = rsp_we_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with zero wait states share a single stimulus driver; sel picks the target.
module tb_dmem_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic        clk;
  logic        rst;
  logic        sel;  // 0 -> u_dut_a (W_A), 1 -> u_dut_b (W_B)

  logic        req_valid;
  logic        req_we;
  logic [29:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic [1:0]  dbg_a, dbg_b;

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_a.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_a.req_wmask = req_wmask;
  assign if_a.req_wdata = req_wdata;
  assign if_a.rsp_ready = rsp_ready & ~sel;

  assign if_b.req_valid = req_valid & sel;
  assign if_b.req_we    = req_we;
  assign if_b.req_addr  = req_addr;
  assign if_b.req_wmask = req_wmask;
  assign if_b.req_wdata = req_wdata;
  assign if_b.rsp_ready = rsp_ready & sel;

  logic        o_req_ready, o_rsp_valid, o_rsp_we;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_state;
  assign o_req_ready = sel ? if_b.req_ready : if_a.req_ready;
  assign o_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign o_rsp_we    = sel ? if_b.rsp_we    : if_a.rsp_we;
  assign o_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
  assign o_state     = sel ? dbg_b          : dbg_a;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state_o(dbg_a)
  );
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state_o(dbg_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic        exp_we_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency();
    int w;
    w = sel ? W_B : W_A;
    return (w == 0) ? 1 : w + 1;
  endfunction

  // Driver: present one request at a negedge, hold it across the accept edge.
  task automatic issue(input logic we, input logic [29:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata);
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wmask = mask;
    req_wdata = wdata;
    exp_q.push_back(exp_rdata);
    exp_we_q.push_back(we);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 30'($urandom);
    req_wdata = $urandom;
  endtask

  // Wait for the response, check latency and payload, optionally stall with
  // rsp_ready=0 while hostile requests are presented, then handshake.
  task automatic collect(input int stall);
    int          n;
    logic [31:0] e_data;
    logic        e_we;
    n = 1;
    while (!o_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(o_rsp_valid), 32'd1);
    check("rsp_latency", 32'(n), 32'(exp_latency()));
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e_data = exp_q.pop_front();
    e_we   = exp_we_q.pop_front();
    check("rsp_rdata", o_rsp_rdata, e_data);
    check("rsp_we", 32'(o_rsp_we), 32'(e_we));
    for (int k = 0; k < stall; k++) begin
      req_valid = (k % 2 == 0);
      req_we    = 1'b1;
      req_addr  = (k % 2 == 0) ? 30'd5 : 30'h405;
      req_wmask = 4'hF;
      req_wdata = 32'h0;
      @(negedge clk);
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rsp_rdata", o_rsp_rdata, e_data);
      check("bp_req_ready", 32'(o_req_ready), 32'd0);
    end
    // Request present in the handshake cycle must not be taken.
    req_valid = (stall > 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("post_req_ready", 32'(o_req_ready), 32'd1);
    check("post_state_idle", 32'(o_state), 32'd0);
  endtask

  initial begin
    sel       = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 30'd0;
    req_wmask = 4'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_rsp_we", 32'(o_rsp_we), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(o_req_ready), 32'd1);

    // Write then read.
    issue(1'b1, 30'd5, 4'hF, 32'hDEADBEEF, 32'h0);
    collect(0);
    issue(1'b0, 30'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    collect(0);

    // Byte mask, then an all-zero mask that must leave the word alone.
    issue(1'b1, 30'd7, 4'hF, 32'h11223344, 32'h0);
    collect(0);
    issue(1'b1, 30'd7, 4'b0101, 32'hAABBCCDD, 32'h0);
    collect(0);
    issue(1'b0, 30'd7, 4'h0, 32'h0, 32'h11BB33DD);
    collect(0);
    issue(1'b1, 30'd7, 4'b0000, 32'hFFFFFFFF, 32'h0);
    collect(0);
    issue(1'b0, 30'd7, 4'h0, 32'h0, 32'h11BB33DD);
    collect(0);

    // Aliasing on the wait-state instance.
    issue(1'b0, 30'h405, 4'h0, 32'h0, 32'hDEADBEEF);
    collect(0);

    // Back-pressure with hostile writes to addr 5; read back afterwards.
    issue(1'b0, 30'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    collect(5);
    issue(1'b0, 30'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    collect(0);

    // Reset during WAIT drops the pending write.
    issue(1'b1, 30'd9, 4'hF, 32'h0, 32'h0);
    collect(0);
    issue(1'b1, 30'd9, 4'hF, 32'hFFFFFFFF, 32'h0);
    check("mid_state_wait", 32'(o_state), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(o_req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_rst_state", 32'(o_state), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_we_q.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 30'd9, 4'h0, 32'h0, 32'h0);
    collect(0);
    issue(1'b0, 30'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    collect(0);

    // Zero wait states and aliasing.
    sel = 1'b1;
    @(negedge clk);
    issue(1'b1, 30'h3, 4'hF, 32'h12345678, 32'h0);
    collect(0);
    issue(1'b0, 30'h403, 4'h0, 32'h0, 32'h12345678);
    collect(0);
    issue(1'b1, 30'h3, 4'b1000, 32'hA5000000, 32'h0);
    collect(2);
    issue(1'b0, 30'h3, 4'h0, 32'h0, 32'hA5345678);
    collect(0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data port: accepts one word-addressed read or byte-masked write request at a time over a valid/ready request channel, models a configurable number of wait states, and returns exactly one response per request over a valid/ready response channel. It sits between the memory stage and a word array. It replaces the zero-latency unified memory on the data side, so the pipeline and its stall logic can be exercised against a slow memory.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of array depth in 32-bit words; only req_addr[DEPTH_LOG2-1:0] indexes the array.
- WAIT_CYCLES, 2: wait states between request acceptance and the access/commit edge; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  30  word address (byte address [31:2]).
- req_wmask  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 32'h0 for write responses.
- rsp_we  out  1  echoes req_we of the request being answered.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - An edge with req_valid=1 is an accept: latch we/addr/wmask/wdata and load cnt=WAIT_CYCLES.
  - If WAIT_CYCLES=0, perform the access at the accept edge and go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Each edge with cnt>1 decrements cnt.
  - The edge with cnt==1 performs the access and goes to RESP.
- Access, single edge:
  - Write: array[addr] lanes with wmask=1 take wdata; other lanes keep their value. rsp_rdata is loaded with 32'h0.
  - Read: rsp_rdata is loaded with array[addr] as it stood before that edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_we are held stable until the handshake.
  - The edge with rsp_ready=1 completes the handshake and returns the FSM to IDLE.
- One outstanding request at most. req_* is ignored outside IDLE.
- Write with wmask=4'b0000: array unchanged; a response is still returned.
- Address bits above DEPTH_LOG2-1 are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- The array is not reset; contents are X until written. The bench must write before reading.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, req_ready=1, rsp_valid=0, rsp_rdata=32'h0, rsp_we=0.
- Reset during WAIT drops the pending request; its write is not committed.
- Writes already committed survive reset.
- Latency, with the accept edge counted as edge 0:
  - The access occurs at edge max(WAIT_CYCLES-1,0)+... specifically: edge 0 if WAIT_CYCLES=0, otherwise edge WAIT_CYCLES.
  - rsp_valid is high in the cycle immediately after the access edge.
- With rsp_ready tied to 1:
  - The response handshake is at edge W+1, where W=WAIT_CYCLES.
  - req_ready is high again after that edge.
  - Minimum request spacing is W+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- A request presented in the same cycle as a response handshake is not accepted, because req_ready=0 in RESP.

## Test plan
- Reset/idle, WAIT_CYCLES=2:
  - Stimulus: hold rst=0, then release it.
  - Required: req_ready=1, rsp_valid=0, rsp_rdata=0 immediately on assertion, with no clock edge needed.
- Write then read, WAIT_CYCLES=2:
  - Stimulus: write addr 5, data 32'hDEADBEEF, mask 4'hF; then read addr 5.
  - Required: write response rsp_rdata=0, rsp_we=1, rsp_valid rising 3 cycles after the accept cycle; read returns 32'hDEADBEEF.
- Byte mask:
  - Stimulus: preload addr 7 with 32'h11223344; write 32'hAABBCCDD with mask 4'b0101; read addr 7.
  - Required: rsp_rdata=32'h11BB33DD.
- Back-pressure:
  - Stimulus: read with rsp_ready=0 for 5 cycles, toggling req_valid and req_addr meanwhile.
  - Required: rsp_valid stays 1, rsp_rdata stable, req_ready=0, no second accept.
- Zero wait and aliasing, WAIT_CYCLES=0, DEPTH_LOG2=10:
  - Stimulus: write addr 0x3 with 32'h12345678; read addr 0x403.
  - Required: rsp_rdata=32'h12345678, response visible one cycle after accept.
- Reset mid-operation:
  - Stimulus: write addr 9, data 32'hFFFFFFFF, mask 4'hF, to a location holding 32'h0; assert rst during WAIT; then read addr 9.
  - Required: rsp_rdata=32'h0, i.e. the write was dropped.
